// File: rtl/sram_uart_fifo.sv
// Byte-lane memory-mapped UART front end with TX/RX FIFOs behind one 8-byte register word.
// Define UART_SIM_PRINT_EN to echo every accepted TX byte to the simulator console.
module sram_uart_fifo #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_6000_0000,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic [63:0] addra,
  input  logic [63:0] dina,
  output logic [63:0] douta,
  input  logic        ena,
  input  logic [7:0]  wea,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [TAW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RAW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           ier_q, ier_d;
  logic           oe_q, oe_d;
  logic [63:0]    douta_q, douta_d;

  logic       hit_s, rd_s, tx_wr_s, ier_wr_s;
  logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_ovf_s;
  logic [7:0] lsr_s, rbr_s;
  logic       unused_s;

  assign hit_s    = ena & ({addra[63:3], 3'b000} == BASE_ADDR);
  assign rd_s     = hit_s & (wea == 8'h00);
  assign tx_wr_s  = hit_s & wea[0];
  assign ier_wr_s = hit_s & wea[1];

  assign tx_full_s  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty_s = (tx_cnt_q == {TCW{1'b0}});
  assign rx_full_s  = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty_s = (rx_cnt_q == {RCW{1'b0}});

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign tx_pop_s  = ~tx_empty_s & tx_ready;
  assign tx_push_s = tx_wr_s & (~tx_full_s | tx_pop_s);
  assign rx_pop_s  = rd_s & (addra[2:0] == 3'd0) & ~rx_empty_s;
  assign rx_push_s = rx_ready & (~rx_full_s | rx_pop_s);
  assign rx_ovf_s  = rx_ready & rx_full_s & ~rx_pop_s;

  assign rbr_s = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
  assign lsr_s = {1'b0, tx_empty_s, ~tx_full_s, 3'b000, oe_q, ~rx_empty_s};

  assign tx_valid = ~tx_empty_s;
  assign tx_data  = tx_empty_s ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
  assign irq      = ier_q & ~rx_empty_s;
  assign douta    = douta_q;
  assign unused_s = ^{dina[63:16], dina[15:9], wea[7:2]};

  // Next-state logic for pointers, counts, control bits and read data.
  always_comb begin
    tx_wr_ptr_d = tx_push_s ? tx_wr_ptr_q + TAW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop_s  ? tx_rd_ptr_q + TAW'(1) : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push_s ? rx_wr_ptr_q + RAW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop_s  ? rx_rd_ptr_q + RAW'(1) : rx_rd_ptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + TCW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TCW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + RCW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RCW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    // A fresh overrun wins over the clear-on-read of the status byte.
    if (rx_ovf_s) begin
      oe_d = 1'b1;
    end else if (rd_s && (addra[2:0] == 3'd5)) begin
      oe_d = 1'b0;
    end else begin
      oe_d = oe_q;
    end
    if (ier_wr_s) begin
      ier_d = dina[8];
    end else begin
      ier_d = ier_q;
    end
    if (rd_s) begin
      douta_d = {16'h0000, lsr_s, 24'h00_0000, 7'h00, ier_q, rbr_s};
    end else begin
      douta_d = douta_q;
    end
  end

  // Control state register.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      tx_wr_ptr_q <= {TAW{1'b0}};
      tx_rd_ptr_q <= {TAW{1'b0}};
      rx_wr_ptr_q <= {RAW{1'b0}};
      rx_rd_ptr_q <= {RAW{1'b0}};
      tx_cnt_q    <= {TCW{1'b0}};
      rx_cnt_q    <= {RCW{1'b0}};
      ier_q       <= 1'b0;
      oe_q        <= 1'b0;
      douta_q     <= 64'h0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      ier_q       <= ier_d;
      oe_q        <= oe_d;
      douta_q     <= douta_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clka) begin
    if (tx_push_s) begin
      tx_mem_q[tx_wr_ptr_q] <= dina[7:0];
    end
    if (rx_push_s) begin
      rx_mem_q[rx_wr_ptr_q] <= rx_data;
    end
  end

`ifdef UART_SIM_PRINT_EN
  // Console echo of accepted TX bytes.
  always_ff @(posedge clka) begin
    if (rstn && tx_push_s) begin
      $write("%c", dina[7:0]);
    end
  end
`else
`endif

endmodule
